// File: rtl/sys_defs_pkg.sv
// Shared definitions for the decode stage: data-width and opcode macros,
// RV32 opcode/funct constants, the instruction field layout and decode helpers.
`ifndef SYS_DEFS_PKG_SV
`define SYS_DEFS_PKG_SV

`define DATA_WIDTH 64
`define ZERO_WORD  {`DATA_WIDTH{1'b0}}
`define INST_ADD   8'h01

package sys_defs_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [2:0] F3_ADD     = 3'b000;
   localparam logic [6:0] F7_ADD     = 7'b0000000;

   typedef enum logic [1:0] {
      CLS_ILLEGAL = 2'd0,
      CLS_ADD     = 2'd1,
      CLS_ADDI    = 2'd2
   } inst_class_e;

   // Field layout of an R/I-type RV instruction word, MSB first.
   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } rv_fields_t;

   function automatic inst_class_e classify(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic [6:0] funct7);
      inst_class_e cls;
      cls = CLS_ILLEGAL;
      if (opcode == OPC_OP && funct3 == F3_ADD && funct7 == F7_ADD)
         cls = CLS_ADD;
      else if (opcode == OPC_OP_IMM && funct3 == F3_ADD)
         cls = CLS_ADDI;
      return cls;
   endfunction

   // Sign-extends the 12-bit I-type immediate held in inst[31:20].
   function automatic logic [`DATA_WIDTH-1:0] sext_imm_i(input logic [11:0] imm);
      return {{(`DATA_WIDTH-12){imm[11]}}, imm};
   endfunction

endpackage

`endif

// File: rtl/id_scoreboard.sv
// Register busy scoreboard: one busy bit per architectural register.
// A set and a clear of the same entry in one cycle leaves it busy; x0 is never busy.
module id_scoreboard
   import sys_defs_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       set_ena,
   input  logic [4:0] set_addr,
   input  logic       clr_ena,
   input  logic [4:0] clr_addr,
   input  logic [4:0] q1_addr,
   input  logic [4:0] q2_addr,
   output logic       q1_busy,
   output logic       q2_busy
);

   logic [31:0] r_busy;

   // Busy-bit update: clear on write-back, set on issue, x0 pinned idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         // NOTE: non-blocking writes to the same bit resolve last-wins, so the
         // set placed after the clear makes a new issue beat a retiring write.
         if (clr_ena)
            r_busy[clr_addr] <= 1'b0;
         if (set_ena)
            r_busy[set_addr] <= 1'b1;
         r_busy[0] <= 1'b0;
      end
   end

   assign q1_busy = r_busy[q1_addr];
   assign q2_busy = r_busy[q2_addr];

endmodule

// File: rtl/id_stage.sv
// Decode stage: decodes ADD/ADDI, reads operands, detects RAW hazards against
// in-flight writes and hands a registered decoded instruction to execute.
// Build option: define ID_BYPASS_EN to forward same-cycle write-back data
// into a busy source instead of stalling on it.
module id_stage
   import sys_defs_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_valid,
   input  logic [31:0]            if_inst,
   output logic                   if_ready,
   output logic [4:0]             rs1_r_addr,
   output logic [4:0]             rs2_r_addr,
   input  logic [`DATA_WIDTH-1:0] rs1_data,
   input  logic [`DATA_WIDTH-1:0] rs2_data,
   input  logic                   wb_ena,
   input  logic [4:0]             wb_addr,
   input  logic [`DATA_WIDTH-1:0] wb_data,
   output logic                   ex_valid,
   input  logic                   ex_ready,
   output logic [7:0]             inst_opcode,
   output logic [`DATA_WIDTH-1:0] op1,
   output logic [`DATA_WIDTH-1:0] op2,
   output logic [4:0]             rd_w_addr,
   output logic                   rd_w_ena,
   output logic                   illegal
);

   rv_fields_t                w_fields;
   inst_class_e               w_class;
   logic                      w_use_rs1;
   logic                      w_use_rs2;
   logic                      w_rs1_busy;
   logic                      w_rs2_busy;
   logic                      w_rs1_wb_hit;
   logic                      w_rs2_wb_hit;
   logic                      w_rs1_stall;
   logic                      w_rs2_stall;
   logic [`DATA_WIDTH-1:0]    w_rs1_val;
   logic [`DATA_WIDTH-1:0]    w_rs2_val;
   logic                      w_hazard;
   logic                      w_accept;

   logic [7:0]                w_dec_opcode;
   logic [`DATA_WIDTH-1:0]    w_dec_op1;
   logic [`DATA_WIDTH-1:0]    w_dec_op2;
   logic                      w_dec_rd_ena;
   logic                      w_dec_illegal;

   logic                      r_ex_valid;
   logic [7:0]                r_inst_opcode;
   logic [`DATA_WIDTH-1:0]    r_op1;
   logic [`DATA_WIDTH-1:0]    r_op2;
   logic [4:0]                r_rd_w_addr;
   logic                      r_rd_w_ena;
   logic                      r_illegal;

   assign w_fields   = rv_fields_t'(if_inst);
   assign w_class    = classify(w_fields.opcode, w_fields.funct3, w_fields.funct7);
   assign w_use_rs1  = (w_class != CLS_ILLEGAL) && (w_fields.rs1 != 5'd0);
   assign w_use_rs2  = (w_class == CLS_ADD)     && (w_fields.rs2 != 5'd0);

   assign rs1_r_addr = w_fields.rs1;
   assign rs2_r_addr = w_fields.rs2;

   id_scoreboard u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .set_ena  (w_accept && w_dec_rd_ena),
      .set_addr (w_fields.rd),
      .clr_ena  (wb_ena),
      .clr_addr (wb_addr),
      .q1_addr  (w_fields.rs1),
      .q2_addr  (w_fields.rs2),
      .q1_busy  (w_rs1_busy),
      .q2_busy  (w_rs2_busy)
   );

   assign w_rs1_wb_hit = wb_ena && (wb_addr == w_fields.rs1);
   assign w_rs2_wb_hit = wb_ena && (wb_addr == w_fields.rs2);

`ifdef ID_BYPASS_EN
   // A busy source being written back this cycle takes the write data directly.
   assign w_rs1_stall = w_use_rs1 && w_rs1_busy && !w_rs1_wb_hit;
   assign w_rs2_stall = w_use_rs2 && w_rs2_busy && !w_rs2_wb_hit;
   assign w_rs1_val   = (w_rs1_busy && w_rs1_wb_hit) ? wb_data : rs1_data;
   assign w_rs2_val   = (w_rs2_busy && w_rs2_wb_hit) ? wb_data : rs2_data;
`else
   // Without forwarding a busy source waits until the register file holds it.
   logic w_unused_wb;
   assign w_unused_wb = ^{wb_data, w_rs1_wb_hit, w_rs2_wb_hit};
   assign w_rs1_stall = w_use_rs1 && w_rs1_busy;
   assign w_rs2_stall = w_use_rs2 && w_rs2_busy;
   assign w_rs1_val   = rs1_data;
   assign w_rs2_val   = rs2_data;
`endif

   assign w_hazard = w_rs1_stall || w_rs2_stall;
   assign if_ready = (!r_ex_valid || ex_ready) && !w_hazard && !rst;
   assign w_accept = if_valid && if_ready;

   // Decode the offered word into the fields execute will receive.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned
      // and infers a latch.
      w_dec_opcode  = 8'h00;
      w_dec_op1     = `ZERO_WORD;
      w_dec_op2     = `ZERO_WORD;
      w_dec_rd_ena  = 1'b0;
      w_dec_illegal = 1'b1;
      case (w_class)
         CLS_ADD: begin
            w_dec_opcode  = `INST_ADD;
            w_dec_op1     = w_rs1_val;
            w_dec_op2     = w_rs2_val;
            w_dec_rd_ena  = (w_fields.rd != 5'd0);
            w_dec_illegal = 1'b0;
         end
         CLS_ADDI: begin
            w_dec_opcode  = `INST_ADD;
            w_dec_op1     = w_rs1_val;
            w_dec_op2     = sext_imm_i(if_inst[31:20]);
            w_dec_rd_ena  = (w_fields.rd != 5'd0);
            w_dec_illegal = 1'b0;
         end
         default: ;
      endcase
   end

   // Output register: load on transfer in, drop valid once execute consumes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ex_valid    <= 1'b0;
         r_inst_opcode <= 8'h00;
         r_op1         <= `ZERO_WORD;
         r_op2         <= `ZERO_WORD;
         r_rd_w_addr   <= 5'd0;
         r_rd_w_ena    <= 1'b0;
         r_illegal     <= 1'b0;
      end else if (w_accept) begin
         r_ex_valid    <= 1'b1;
         r_inst_opcode <= w_dec_opcode;
         r_op1         <= w_dec_op1;
         r_op2         <= w_dec_op2;
         r_rd_w_addr   <= w_fields.rd;
         r_rd_w_ena    <= w_dec_rd_ena;
         r_illegal     <= w_dec_illegal;
      end else if (ex_ready) begin
         r_ex_valid    <= 1'b0;
      end
   end

   assign ex_valid    = r_ex_valid;
   assign inst_opcode = r_inst_opcode;
   assign op1         = r_op1;
   assign op2         = r_op2;
   assign rd_w_addr   = r_rd_w_addr;
   assign rd_w_ena    = r_rd_w_ena;
   assign illegal     = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed instruction vectors with hand-computed results.
// Stimulus pushes the expected decoded instruction when it is accepted; a
// monitor pops and compares each time execute consumes an output.
module tb_id_stage;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   if_valid;
   logic [31:0]            if_inst;
   logic                   if_ready;
   logic [4:0]             rs1_r_addr;
   logic [4:0]             rs2_r_addr;
   logic [`DATA_WIDTH-1:0] rs1_data;
   logic [`DATA_WIDTH-1:0] rs2_data;
   logic                   wb_ena;
   logic [4:0]             wb_addr;
   logic [`DATA_WIDTH-1:0] wb_data;
   logic                   ex_valid;
   logic                   ex_ready;
   logic [7:0]             inst_opcode;
   logic [`DATA_WIDTH-1:0] op1;
   logic [`DATA_WIDTH-1:0] op2;
   logic [4:0]             rd_w_addr;
   logic                   rd_w_ena;
   logic                   illegal;

   always #5 clk = ~clk;

   id_stage dut (
      .clk         (clk),
      .rst         (rst),
      .if_valid    (if_valid),
      .if_inst     (if_inst),
      .if_ready    (if_ready),
      .rs1_r_addr  (rs1_r_addr),
      .rs2_r_addr  (rs2_r_addr),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .wb_ena      (wb_ena),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .ex_valid    (ex_valid),
      .ex_ready    (ex_ready),
      .inst_opcode (inst_opcode),
      .op1         (op1),
      .op2         (op2),
      .rd_w_addr   (rd_w_addr),
      .rd_w_ena    (rd_w_ena),
      .illegal     (illegal)
   );

   typedef struct packed {
      logic [7:0]  opc;
      logic [63:0] op1;
      logic [63:0] op2;
      logic [4:0]  rd;
      logic        ena;
      logic        ill;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam logic [31:0] I_ADDI_X1_5   = 32'h0050_0093;
   localparam logic [31:0] I_ADDI_X2_M1  = 32'hFFF0_0113;
   localparam logic [31:0] I_ADD_X3      = 32'h0020_81B3;
   localparam logic [31:0] I_ADDI_X4_9   = 32'h0090_0213;
   localparam logic [31:0] I_ADDI_X5_3   = 32'h0030_0293;
   localparam logic [31:0] I_ADDI_X6_5   = 32'h0050_0313;
   localparam logic [31:0] I_ECALL       = 32'h0000_0073;
   localparam logic [31:0] I_SUB_X7      = 32'h4020_83B3;
   localparam logic [31:0] I_ADD_X8      = 32'h0003_8433;
   localparam logic [31:0] I_ADDI_X9_2   = 32'h0020_0493;
   localparam logic [31:0] I_ADD_X10     = 32'h0004_8533;
   localparam logic [31:0] I_ADDI_X1_1   = 32'h0010_0093;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] opc, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd, input logic ena, input logic ill);
      exp_t e;
      e.opc = opc; e.op1 = a; e.op2 = b; e.rd = rd; e.ena = ena; e.ill = ill;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction and wait (bounded) for the handshake.
   task automatic issue(input logic [31:0] inst, input logic [63:0] r1, input logic [63:0] r2,
                        input exp_t e, output int waited);
      bit done;
      if_valid = 1'b1;
      if_inst  = inst;
      rs1_data = r1;
      rs2_data = r2;
      waited   = 0;
      done     = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (if_ready) begin
            exp_q.push_back(e);
            done = 1'b1;
         end else begin
            waited++;
         end
         tick();
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL issue_timeout: inst %h never accepted within 20 cycles", inst);
      end
      if_valid = 1'b0;
   endtask

   // Offer an ADD whose rs1 is busy, then retire that register with new_val.
   task automatic hazard_issue(input logic [31:0] inst, input logic [4:0] src,
                               input logic [63:0] stale, input logic [63:0] new_val,
                               input logic [63:0] rs2_val, input logic [4:0] rd);
      if_valid = 1'b1;
      if_inst  = inst;
      rs1_data = stale;
      rs2_data = rs2_val;
      wb_ena   = 1'b0;
      @(negedge clk);
      check("hazard_stall_ready", if_ready, 1'b0);
      tick();
      wb_ena  = 1'b1;
      wb_addr = src;
      wb_data = new_val;
      @(negedge clk);
`ifdef ID_BYPASS_EN
      check("bypass_ready", if_ready, 1'b1);
      exp_q.push_back(mk(`INST_ADD, new_val, rs2_val, rd, 1'b1, 1'b0));
      tick();
      wb_ena = 1'b0;
`else
      check("wb_cycle_stall_ready", if_ready, 1'b0);
      tick();
      wb_ena   = 1'b0;
      rs1_data = new_val;
      @(negedge clk);
      check("post_wb_ready", if_ready, 1'b1);
      exp_q.push_back(mk(`INST_ADD, new_val, rs2_val, rd, 1'b1, 1'b0));
      tick();
`endif
      if_valid = 1'b0;
   endtask

   // Monitor: compare every instruction execute consumes against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_issue: opcode %h rd %0d with nothing expected",
                        inst_opcode, rd_w_addr);
            end else begin
               e = exp_q.pop_front();
               check("out_opcode",   inst_opcode, e.opc);
               check("out_op1",      op1,         e.op1);
               check("out_op2",      op2,         e.op2);
               check("out_rd_addr",  rd_w_addr,   e.rd);
               check("out_rd_ena",   rd_w_ena,    e.ena);
               check("out_illegal",  illegal,     e.ill);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      rst      = 1'b1;
      if_valid = 1'b0;
      if_inst  = 32'h0;
      rs1_data = '0;
      rs2_data = '0;
      wb_ena   = 1'b0;
      wb_addr  = 5'd0;
      wb_data  = '0;
      ex_ready = 1'b1;
      repeat (2) tick();
      rst = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_ex_valid",  ex_valid,    1'b0);
      check("rst_opcode",    inst_opcode, 8'h00);
      check("rst_op1",       op1,         64'h0);
      check("rst_op2",       op2,         64'h0);
      check("rst_rd_addr",   rd_w_addr,   5'd0);
      check("rst_rd_ena",    rd_w_ena,    1'b0);
      check("rst_illegal",   illegal,     1'b0);
      check("rst_if_ready",  if_ready,    1'b1);

      // Register-file read addresses follow the word combinationally.
      if_inst = I_ADD_X3;
      #1;
      check("rs1_r_addr", rs1_r_addr, 5'd1);
      check("rs2_r_addr", rs2_r_addr, 5'd2);
      tick();

      // ADDI x1,x0,5 then ADDI x2,x0,-1 back to back.
      issue(I_ADDI_X1_5, 64'h0, 64'h0, mk(`INST_ADD, 64'h0, 64'h5, 5'd1, 1'b1, 1'b0), w);
      check("addi_first_wait", w, 0);
      issue(I_ADDI_X2_M1, 64'h0, 64'h0,
            mk(`INST_ADD, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 1'b1, 1'b0), w);
      check("back_to_back_wait", w, 0);

      // Retire x2 so only x1 is outstanding.
      wb_ena  = 1'b1;
      wb_addr = 5'd2;
      wb_data = 64'd10;
      tick();
      wb_ena  = 1'b0;

      // ADD x3,x1,x2 stalls on x1 until its write-back of 7.
      hazard_issue(I_ADD_X3, 5'd1, 64'd99, 64'd7, 64'd10, 5'd3);

      // Execute back-pressure: held outputs stable, fetch blocked.
      issue(I_ADDI_X4_9, 64'h0, 64'h0, mk(`INST_ADD, 64'h0, 64'h9, 5'd4, 1'b1, 1'b0), w);
      check("addi_x4_wait", w, 0);
      ex_ready = 1'b0;
      if_valid = 1'b1;
      if_inst  = I_ADDI_X5_3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_if_ready", if_ready,    1'b0);
         check("stall_ex_valid", ex_valid,    1'b1);
         check("stall_opcode",   inst_opcode, `INST_ADD);
         check("stall_op2",      op2,         64'h9);
         check("stall_rd_addr",  rd_w_addr,   5'd4);
         tick();
      end
      ex_ready = 1'b1;
      @(negedge clk);
      check("release_if_ready", if_ready, 1'b1);
      exp_q.push_back(mk(`INST_ADD, 64'h0, 64'h3, 5'd5, 1'b1, 1'b0));
      tick();
      if_valid = 1'b0;

      // ADDI's rs2 field names busy x5 but is not a source.
      issue(I_ADDI_X6_5, 64'h0, 64'h0, mk(`INST_ADD, 64'h0, 64'h5, 5'd6, 1'b1, 1'b0), w);
      check("addi_rs2_not_hazard", w, 0);

      // Illegal words: zeroed operands, no write, no busy bit.
      issue(I_ECALL, 64'h55, 64'h66, mk(8'h00, 64'h0, 64'h0, 5'd0, 1'b0, 1'b1), w);
      check("ecall_wait", w, 0);
      issue(I_SUB_X7, 64'h55, 64'h66, mk(8'h00, 64'h0, 64'h0, 5'd7, 1'b0, 1'b1), w);
      check("sub_wait", w, 0);
      issue(I_ADD_X8, 64'h21, 64'h0, mk(`INST_ADD, 64'h21, 64'h0, 5'd8, 1'b1, 1'b0), w);
      check("illegal_no_busy", w, 0);

      // Issue of x9 while x9 retires: entry stays busy.
      wb_ena  = 1'b1;
      wb_addr = 5'd9;
      wb_data = 64'h0;
      issue(I_ADDI_X9_2, 64'h0, 64'h0, mk(`INST_ADD, 64'h0, 64'h2, 5'd9, 1'b1, 1'b0), w);
      wb_ena  = 1'b0;
      hazard_issue(I_ADD_X10, 5'd9, 64'h33, 64'd4, 64'h0, 5'd10);

      // Reset while execute is stalled and fetch is blocked on a hazard.
      issue(I_ADDI_X1_1, 64'h0, 64'h0, mk(`INST_ADD, 64'h0, 64'h1, 5'd1, 1'b1, 1'b0), w);
      ex_ready = 1'b0;
      if_valid = 1'b1;
      if_inst  = I_ADD_X3;
      rs1_data = 64'h10;
      rs2_data = 64'h20;
      @(negedge clk);
      check("pre_rst_if_ready", if_ready, 1'b0);
      tick();
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("in_rst_if_ready", if_ready, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ex_valid", ex_valid, 1'b0);
      check("post_rst_rd_ena",   rd_w_ena, 1'b0);
      check("post_rst_op1",      op1,      64'h0);
      check("post_rst_if_ready", if_ready, 1'b1);
      exp_q.push_back(mk(`INST_ADD, 64'h10, 64'h20, 5'd3, 1'b1, 1'b0));
      tick();
      if_valid = 1'b0;
      ex_ready = 1'b1;

      repeat (3) tick();
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be `DATA_WIDTH (64) and the opcode width 8.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_valid  input  1  fetch is offering if_inst.
REQ-005 if_inst  input  32  RV instruction word.
REQ-006 if_ready  output  1  decode accepts if_inst this cycle.
REQ-007 rs1_r_addr, rs2_r_addr  output  5 each  combinational register-file read addresses.
REQ-008 rs1_data, rs2_data  input  `DATA_WIDTH each  same-cycle register-file read data.
REQ-009 wb_ena  input  1  register-file write this cycle.
REQ-010 wb_addr  input  5  write address; wb_data  input  `DATA_WIDTH  write data.
REQ-011 ex_valid  output  1  registered outputs below hold a decoded instruction.
REQ-012 ex_ready  input  1  execute consumes the held instruction this cycle.
REQ-013 inst_opcode  output  8; op1, op2  output  `DATA_WIDTH each; rd_w_addr  output  5; rd_w_ena  output  1; illegal  output  1 -- all registered.

Function
REQ-014 rs1_r_addr SHALL be if_inst[19:15] and rs2_r_addr SHALL be if_inst[24:20] at all times.
REQ-015 ADD (opcode 0110011, funct3 000, funct7 0000000) SHALL decode to `INST_ADD with op1=rs1 value, op2=rs2 value, rd_w_ena=1.
REQ-016 ADDI (opcode 0010011, funct3 000) SHALL decode to `INST_ADD with op1=rs1 value, op2=sign-extended imm[31:20], rd_w_ena=1; rs2 SHALL NOT be a hazard source.
REQ-017 Any other word SHALL decode to inst_opcode=8'h00, op1=op2=`ZERO_WORD, rd_w_ena=0, illegal=1, with no hazard check.
REQ-018 rd_w_addr SHALL be if_inst[11:7]; rd_w_ena SHALL be forced to 0 when rd=x0.
REQ-019 A 32-entry busy scoreboard SHALL mark rd busy on acceptance of an instruction with rd_w_ena=1 and clear the entry on wb_ena for wb_addr; x0 is never busy.
REQ-020 Simultaneous set and clear of the same entry SHALL leave it busy (the new issue wins).
REQ-021 hazard SHALL be asserted when a used source register (rs != x0) is busy and not resolved per REQ-028/029.
REQ-022 if_ready SHALL be (!ex_valid || ex_ready) && !hazard && !rst.
REQ-023 Transfer in SHALL occur when if_valid && if_ready; outputs SHALL load on that edge (latency 1 cycle) and ex_valid SHALL be 1 the next cycle.
REQ-024 When ex_valid && ex_ready and no transfer in, ex_valid SHALL drop to 0; held outputs SHALL stay stable while ex_valid && !ex_ready.
REQ-025 Back-to-back issue SHALL sustain one instruction per cycle when there are no hazards.

Reset
REQ-026 On rst the block SHALL clear ex_valid, illegal, and rd_w_ena, set inst_opcode to 8'h00, set op1/op2 to `ZERO_WORD, set rd_w_addr to 0, and clear all busy bits; reset mid-stall SHALL discard the pending instruction.

Configuration
REQ-027 Macro ID_BYPASS_EN SHALL select the write-back bypass.
REQ-028 With ID_BYPASS_EN defined, a busy source matched by wb_ena && wb_addr this cycle SHALL take wb_data and SHALL NOT stall.
REQ-029 Without ID_BYPASS_EN, a busy source SHALL stall even when written this cycle, and SHALL issue the following cycle using rs data.

Structure
REQ-030 `DATA_WIDTH, `ZERO_WORD, `INST_ADD, the RV opcode/funct constants and a decoded-fields struct SHALL live in the shared sys_defs definitions.
REQ-031 The scoreboard SHALL be a sub-module id_scoreboard (set port, clear port, two query ports, 32 busy bits).

Verification
REQ-032 Reset, then ADDI x1,x0,5 with rs1_data=0 -> next cycle ex_valid=1, opcode=`INST_ADD, op1=0, op2=5, rd_w_addr=1, rd_w_ena=1.
REQ-033 ADDI x2,x0,-1 -> op2=64'hFFFF_FFFF_FFFF_FFFF.
REQ-034 ADD x3,x1,x2 while x1 is busy -> if_ready=0; then wb_ena, wb_addr=1, wb_data=7: with bypass, issue that cycle with op1=7; without bypass, issue one cycle later.
REQ-035 ex_ready=0 for 3 cycles with if_valid=1 -> outputs stable, if_ready=0; ex_ready=1 -> next instruction loads.
REQ-036 if_inst=32'h0000_0073 (ecall) -> illegal=1, rd_w_ena=0, no busy bit set.
REQ-037 rst during a stall -> ex_valid=0 and scoreboard clear next cycle; ADD x3,x1,x2 then issues immediately.
